ex_fwd_ctrl: RTL and testbench



---
 rtl/ex_fwd_ctrl_pkg.sv | 63 ++++++
 rtl/ex_fwd_ctrl_if.sv | 25 ++
 rtl/ex_fwd_ctrl_fwd_src_cmp.sv | 31 +++
 rtl/ex_fwd_ctrl.sv | 96 +++++++++
 tb/tb_ex_fwd_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_fwd_ctrl_pkg.sv
// Shared types and decode helpers for the EX-stage forwarding controller.
// The opcodes are RV32I major opcodes. The helpers report which register
// fields each instruction class actually reads or writes.
package ex_fwd_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [6:0] opcode_t;

  localparam opcode_t OPC_R      = 7'b0110011;
  localparam opcode_t OPC_I      = 7'b0010011;
  localparam opcode_t OPC_LUI    = 7'b0110111;
  localparam opcode_t OPC_AUIPC  = 7'b0010111;
  localparam opcode_t OPC_JAL    = 7'b1101111;
  localparam opcode_t OPC_JALR   = 7'b1100111;
  localparam opcode_t OPC_LOAD   = 7'b0000011;
  localparam opcode_t OPC_STORE  = 7'b0100011;
  localparam opcode_t OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    RS_EX_SEL  = 2'd0,
    MEM_EX_SEL = 2'd1,
    WB_EX_SEL  = 2'd2
  } ex_fwd_sel_t;

  typedef struct packed {
    opcode_t               opcode;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
  } instr_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wr_en;
    logic                  is_load;
  } fwd_rec_t;

  function automatic logic writes_rd(input opcode_t op);
    return op inside {OPC_R, OPC_I, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD};
  endfunction

  function automatic logic uses_rs1(input opcode_t op);
    return op inside {OPC_R, OPC_I, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_JALR};
  endfunction

  function automatic logic uses_rs2(input opcode_t op);
    return op inside {OPC_R, OPC_BRANCH, OPC_STORE};
  endfunction

  // JALR reads rs1 only through the raw path; its ALU A input is the PC.
  function automatic logic alu_a_uses_rs1(input opcode_t op);
    return op inside {OPC_R, OPC_I, OPC_BRANCH, OPC_LOAD, OPC_STORE};
  endfunction

  // Stores route rs2 through the raw path, so ALU B keeps the immediate.
  function automatic logic alu_b_uses_rs2(input opcode_t op);
    return op inside {OPC_R, OPC_BRANCH};
  endfunction

endpackage

// File: rtl/ex_fwd_ctrl_if.sv
// ID-side request signals and EX-side forwarding selects of the forwarding controller.
interface ex_fwd_ctrl_if;
  import ex_fwd_ctrl_pkg::*;

  instr_t      id_instr;
  logic        id_valid;
  logic        stall_in;
  logic        flush;
  ex_fwd_sel_t fwd_a;
  ex_fwd_sel_t fwd_b;
  ex_fwd_sel_t fwd_rs1_raw;
  ex_fwd_sel_t fwd_rs2_raw;
  logic        load_use_stall;
  logic        ex_valid;

  modport master (
    output id_instr, id_valid, stall_in, flush,
    input  fwd_a, fwd_b, fwd_rs1_raw, fwd_rs2_raw, load_use_stall, ex_valid
  );

  modport slave (
    input  id_instr, id_valid, stall_in, flush,
    output fwd_a, fwd_b, fwd_rs1_raw, fwd_rs2_raw, load_use_stall, ex_valid
  );
endinterface

// File: rtl/ex_fwd_ctrl_fwd_src_cmp.sv
// Compares one source register index against the EX and MEM producer records.
// It returns the raw forward select and whether the EX match is a pending load.
module ex_fwd_ctrl_fwd_src_cmp
  import ex_fwd_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src,
  input  fwd_rec_t              ex_rec,
  input  fwd_rec_t              mem_rec,
  output ex_fwd_sel_t           sel,
  output logic                  ex_load_hit
);

  logic ex_match;
  logic mem_match;

  assign ex_match  = ex_rec.valid  && ex_rec.wr_en  && (ex_rec.rd  == src) && (src != '0);
  assign mem_match = mem_rec.valid && mem_rec.wr_en && (mem_rec.rd == src) && (src != '0);

  // The EX record is the younger producer, so it wins over MEM.
  always_comb begin
    sel = RS_EX_SEL;
    if (ex_match) begin
      sel = MEM_EX_SEL;
    end else if (mem_match) begin
      sel = WB_EX_SEL;
    end
  end

  assign ex_load_hit = ex_match && ex_rec.is_load;

endmodule

// File: rtl/ex_fwd_ctrl.sv
// EX-stage forwarding and load-use hazard controller with its own shadow pipeline.
// Selects are registered so that they line up with the cycle the instruction spends in EX.
module ex_fwd_ctrl
  import ex_fwd_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  ex_fwd_ctrl_if.slave bus
);

  // No WB record is kept: a producer that reaches WB while its consumer is
  // still in ID has retired by the consumer's EX cycle. The write-first
  // register file supplies that value.
  fwd_rec_t    ex_rec_reg,  ex_rec_next;
  fwd_rec_t    mem_rec_reg;
  ex_fwd_sel_t fwd_a_reg,   fwd_a_next;
  ex_fwd_sel_t fwd_b_reg,   fwd_b_next;
  ex_fwd_sel_t fwd_rs1_reg, fwd_rs1_next;
  ex_fwd_sel_t fwd_rs2_reg, fwd_rs2_next;

  opcode_t               id_op;
  logic [REG_ADDR_W-1:0] src_idx  [2];
  ex_fwd_sel_t           raw_sel  [2];
  logic                  load_hit [2];
  logic                  load_use;
  logic                  bubble;

  assign id_op      = bus.id_instr.opcode;
  assign src_idx[0] = bus.id_instr.rs1;
  assign src_idx[1] = bus.id_instr.rs2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
      ex_fwd_ctrl_fwd_src_cmp u_cmp (
        .src         (src_idx[gi]),
        .ex_rec      (ex_rec_reg),
        .mem_rec     (mem_rec_reg),
        .sel         (raw_sel[gi]),
        .ex_load_hit (load_hit[gi])
      );
    end
  endgenerate

  always_comb begin
    load_use = 1'b0;
    bubble   = 1'b1;
    ex_rec_next  = '0;
    fwd_a_next   = RS_EX_SEL;
    fwd_b_next   = RS_EX_SEL;
    fwd_rs1_next = RS_EX_SEL;
    fwd_rs2_next = RS_EX_SEL;

    // Only sources the instruction really reads can cause a stall.
    load_use = bus.id_valid && !bus.flush &&
               ((uses_rs1(id_op) && load_hit[0]) || (uses_rs2(id_op) && load_hit[1]));
    bubble   = bus.flush || load_use || !bus.id_valid;

    if (!bubble) begin
      ex_rec_next.valid   = 1'b1;
      ex_rec_next.rd      = bus.id_instr.rd;
      ex_rec_next.wr_en   = writes_rd(id_op) && (bus.id_instr.rd != '0);
      ex_rec_next.is_load = (id_op == OPC_LOAD);
      fwd_rs1_next = raw_sel[0];
      fwd_rs2_next = raw_sel[1];
      // A non-RS select would override pc/imm in the operand mux.
      if (alu_a_uses_rs1(id_op)) fwd_a_next = raw_sel[0];
      if (alu_b_uses_rs2(id_op)) fwd_b_next = raw_sel[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rec_reg  <= '0;
      mem_rec_reg <= '0;
      fwd_a_reg   <= RS_EX_SEL;
      fwd_b_reg   <= RS_EX_SEL;
      fwd_rs1_reg <= RS_EX_SEL;
      fwd_rs2_reg <= RS_EX_SEL;
    end else if (!bus.stall_in) begin
      mem_rec_reg <= ex_rec_reg;
      ex_rec_reg  <= ex_rec_next;
      fwd_a_reg   <= fwd_a_next;
      fwd_b_reg   <= fwd_b_next;
      fwd_rs1_reg <= fwd_rs1_next;
      fwd_rs2_reg <= fwd_rs2_next;
    end
  end

  assign bus.fwd_a          = fwd_a_reg;
  assign bus.fwd_b          = fwd_b_reg;
  assign bus.fwd_rs1_raw    = fwd_rs1_reg;
  assign bus.fwd_rs2_raw    = fwd_rs2_reg;
  assign bus.load_use_stall = load_use;
  assign bus.ex_valid       = ex_rec_reg.valid;

endmodule

// File: tb/tb_ex_fwd_ctrl.sv
// Directed and random stimulus for ex_fwd_ctrl, checked against an age-ordered producer history model.
module tb_ex_fwd_ctrl;
  import ex_fwd_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_fwd_ctrl_if bus ();

  ex_fwd_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: producers still able to forward, youngest first.
  // Age 0 resolves to MEM_EX_SEL and age 1 resolves to WB_EX_SEL.
  typedef struct {
    bit       valid;
    bit [4:0] rd;
    bit       writes;
    bit       load;
  } prod_t;

  prod_t hist[$];
  logic [1:0] exp_a, exp_b, exp_r1, exp_r2;
  logic       exp_exv;
  int passes = 0;
  int total  = 0;
  int stepno = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit m_wr(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
      7'b1101111, 7'b1100111, 7'b0000011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_rd1(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b1100011, 7'b0000011, 7'b0100011, 7'b1100111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_rd2(input logic [6:0] op);
    return (op == 7'b0110011) || (op == 7'b1100011) || (op == 7'b0100011);
  endfunction

  function automatic bit m_alu_a(input logic [6:0] op);
    return m_rd1(op) && (op != 7'b1100111);
  endfunction

  function automatic bit m_alu_b(input logic [6:0] op);
    return (op == 7'b0110011) || (op == 7'b1100011);
  endfunction

  // Returns the age of the youngest producer of s, or -1 when there is none.
  function automatic int producer_age(input bit [4:0] s);
    if (s == 0) return -1;
    for (int i = 0; i < hist.size(); i++)
      if (hist[i].valid && hist[i].writes && hist[i].rd == s) return i;
    return -1;
  endfunction

  function automatic logic [1:0] age_sel(input int age);
    if (age == 0) return 2'd1;
    if (age == 1) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit m_lus(input instr_t ins, input bit v, input bit fl);
    bit hit = 0;
    if (!v || fl) return 0;
    if (m_rd1(ins.opcode) && producer_age(ins.rs1) == 0 && hist[0].load) hit = 1;
    if (m_rd2(ins.opcode) && producer_age(ins.rs2) == 0 && hist[0].load) hit = 1;
    return hit;
  endfunction

  task automatic model_reset();
    prod_t empty = '{0, 0, 0, 0};
    hist = {};
    hist.push_back(empty);
    hist.push_back(empty);
    exp_a = 0; exp_b = 0; exp_r1 = 0; exp_r2 = 0; exp_exv = 0;
  endtask

  function automatic instr_t mk(input logic [6:0] op, input int rd, input int rs1, input int rs2);
    instr_t t;
    t.opcode = op; t.rd = rd[4:0]; t.rs1 = rs1[4:0]; t.rs2 = rs2[4:0];
    return t;
  endfunction

  task automatic step(input instr_t ins, input bit v, input bit fl, input bit st, output bit lus);
    prod_t p;
    logic [1:0] s1, s2;
    @(negedge clk);
    bus.id_instr = ins; bus.id_valid = v; bus.flush = fl; bus.stall_in = st;
    #1;
    lus = m_lus(ins, v, fl);
    chk("load_use_stall", {7'd0, bus.load_use_stall}, {7'd0, lus});
    s1 = age_sel(producer_age(ins.rs1));
    s2 = age_sel(producer_age(ins.rs2));
    if (!st) begin
      if (fl || lus || !v) begin
        p = '{0, 0, 0, 0};
        exp_a = 0; exp_b = 0; exp_r1 = 0; exp_r2 = 0;
      end else begin
        p = '{1, ins.rd, m_wr(ins.opcode) && ins.rd != 0, ins.opcode == 7'b0000011};
        exp_r1 = s1; exp_r2 = s2;
        exp_a = m_alu_a(ins.opcode) ? s1 : 2'd0;
        exp_b = m_alu_b(ins.opcode) ? s2 : 2'd0;
      end
      hist.push_front(p);
      void'(hist.pop_back());
      exp_exv = p.valid;
    end
    @(posedge clk);
    #1;
    stepno++;
    $display("step %0d op=%b rd=%0d rs1=%0d rs2=%0d v=%0b fl=%0b st=%0b -> lus=%0b a=%0d b=%0d r1=%0d r2=%0d exv=%0b",
             stepno, ins.opcode, ins.rd, ins.rs1, ins.rs2, v, fl, st, lus,
             bus.fwd_a, bus.fwd_b, bus.fwd_rs1_raw, bus.fwd_rs2_raw, bus.ex_valid);
    chk("fwd_a", {6'd0, bus.fwd_a}, {6'd0, exp_a});
    chk("fwd_b", {6'd0, bus.fwd_b}, {6'd0, exp_b});
    chk("fwd_rs1_raw", {6'd0, bus.fwd_rs1_raw}, {6'd0, exp_r1});
    chk("fwd_rs2_raw", {6'd0, bus.fwd_rs2_raw}, {6'd0, exp_r2});
    chk("ex_valid", {7'd0, bus.ex_valid}, {7'd0, exp_exv});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_fwd_a"}, {6'd0, bus.fwd_a}, 8'd0);
    chk({tag, "_fwd_b"}, {6'd0, bus.fwd_b}, 8'd0);
    chk({tag, "_rs1_raw"}, {6'd0, bus.fwd_rs1_raw}, 8'd0);
    chk({tag, "_rs2_raw"}, {6'd0, bus.fwd_rs2_raw}, 8'd0);
    chk({tag, "_ex_valid"}, {7'd0, bus.ex_valid}, 8'd0);
    chk({tag, "_lus"}, {7'd0, bus.load_use_stall}, 8'd0);
  endtask

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, SW = 7'b0100011;
  localparam logic [6:0] JAL = 7'b1101111;

  initial begin
    bit l;
    bit hold;
    instr_t cur;
    logic [6:0] ops [9];
    ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
            7'b1100111, 7'b0000011, 7'b0100011, 7'b1100011};

    bus.id_instr = '0; bus.id_valid = 0; bus.flush = 0; bus.stall_in = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1;

    // add x5,x1,x2 ; sub x6,x5,x3
    step(mk(R, 5, 1, 2), 1, 0, 0, l);
    step(mk(R, 6, 5, 3), 1, 0, 0, l);
    chk("addsub_fwd_a", {6'd0, bus.fwd_a}, 8'd1);
    chk("addsub_fwd_b", {6'd0, bus.fwd_b}, 8'd0);

    // lw x5,0(x1) ; add x6,x2,x5: one bubble, then WB forward
    step(mk(LD, 5, 1, 0), 1, 0, 0, l);
    step(mk(R, 6, 2, 5), 1, 0, 0, l);
    chk("lu_stall_seen", {7'd0, l}, 8'd1);
    chk("lu_bubble_exv", {7'd0, bus.ex_valid}, 8'd0);
    step(mk(R, 6, 2, 5), 1, 0, 0, l);
    chk("lu_once", {7'd0, l}, 8'd0);
    chk("lu_fwd_b", {6'd0, bus.fwd_b}, 8'd2);
    chk("lu_fwd_a", {6'd0, bus.fwd_a}, 8'd0);

    // nearest producer wins
    step(mk(R, 5, 1, 2), 1, 0, 0, l);
    step(mk(R, 5, 3, 4), 1, 0, 0, l);
    step(mk(R, 7, 5, 5), 1, 0, 0, l);
    chk("near_fwd_a", {6'd0, bus.fwd_a}, 8'd1);
    chk("near_fwd_b", {6'd0, bus.fwd_b}, 8'd1);

    // x0 is never forwarded
    step(mk(I, 0, 1, 0), 1, 0, 0, l);
    step(mk(R, 6, 0, 0), 1, 0, 0, l);
    chk("x0_fwd_a", {6'd0, bus.fwd_a}, 8'd0);
    chk("x0_fwd_b", {6'd0, bus.fwd_b}, 8'd0);

    // store reads rs2 only through the raw path
    step(mk(R, 5, 1, 2), 1, 0, 0, l);
    step(mk(SW, 0, 5, 5), 1, 0, 0, l);
    chk("sw_fwd_a", {6'd0, bus.fwd_a}, 8'd1);
    chk("sw_fwd_b", {6'd0, bus.fwd_b}, 8'd0);
    chk("sw_rs2_raw", {6'd0, bus.fwd_rs2_raw}, 8'd1);

    // jal never forwards into ALU A
    step(mk(R, 5, 1, 2), 1, 0, 0, l);
    step(mk(JAL, 1, 5, 5), 1, 0, 0, l);
    chk("jal_fwd_a", {6'd0, bus.fwd_a}, 8'd0);

    // a flush in the same cycle as a load-use hazard wins
    step(mk(LD, 5, 1, 0), 1, 0, 0, l);
    step(mk(R, 6, 5, 5), 1, 1, 0, l);
    chk("flush_lus", {7'd0, l}, 8'd0);
    chk("flush_exv", {7'd0, bus.ex_valid}, 8'd0);
    chk("flush_fwd_a", {6'd0, bus.fwd_a}, 8'd0);

    // three-cycle freeze, then forwarding from the held producer
    step(mk(R, 5, 1, 2), 1, 0, 0, l);
    repeat (3) step(mk(R, 7, 5, 1), 1, 0, 1, l);
    step(mk(R, 7, 5, 1), 1, 0, 0, l);
    chk("stall_rel_fwd_a", {6'd0, bus.fwd_a}, 8'd1);

    // asynchronous reset while a load sits in EX
    step(mk(LD, 5, 1, 0), 1, 0, 0, l);
    @(negedge clk);
    bus.id_instr = mk(R, 6, 5, 5); bus.id_valid = 1;
    #2 rst_n = 0;
    #1;
    model_reset();
    chk_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1;
    step(mk(R, 6, 5, 5), 1, 0, 0, l);
    chk("post_rst_fwd_a", {6'd0, bus.fwd_a}, 8'd0);

    // random stream; a stalled or frozen ID instruction is presented again
    hold = 0;
    cur = '0;
    for (int i = 0; i < 200; i++) begin
      bit v, fl, st;
      if (!hold)
        cur = mk(ops[$urandom_range(0, 8)], $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      v  = ($urandom_range(0, 9) != 0);
      fl = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 9) == 0);
      step(cur, v, fl, st, l);
      hold = st || l;
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
